// File: rtl/reg_file_sb_if.sv
// Register-file access bundle: writeback, issue and two read ports.
// master = datapath side driving requests, slave = the register file.
interface reg_file_sb_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] rd_addr0;
  logic [WIDTH-1:0]  rd_data0;
  logic              pend0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [WIDTH-1:0]  rd_data1;
  logic              pend1;

  modport master (
    output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr0, rd_addr1,
    input  rd_data0, pend0, rd_data1, pend1
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr0, rd_addr1,
    output rd_data0, pend0, rd_data1, pend1
  );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-entry register file with one write port, two combinational read
// ports, optional write->read forwarding, optional hard-zero entry 0 and a
// per-entry pending (RAW hazard) scoreboard.

// One combinational read port: entry select, out-of-range -> 0, forwarding.
module reg_file_sb_rdport #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic [NREGS-1:0][WIDTH-1:0] mem_i,
  input  logic [NREGS-1:0]            pend_i,
  input  logic [ADDR_W-1:0]           rd_addr_i,
  input  logic                        wr_ok_i,
  input  logic [ADDR_W-1:0]           wr_addr_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic                        pend_o
);
  // Decode by scanning valid entries so indices >= NREGS fall through to 0.
  // wr_ok_i already excludes the hard-zero and out-of-range cases, so the
  // forward path never fires for them.
  always_comb begin
    rd_data_o = '0;
    pend_o    = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        rd_data_o = mem_i[i];
        pend_o    = pend_i[i];
      end
    end
    if (BYPASS != 0 && wr_ok_i && wr_addr_i == rd_addr_i) begin
      rd_data_o = wr_data_i;
      pend_o    = 1'b0;
    end
  end
endmodule

module reg_file_sb #(
  parameter int               WIDTH     = 16,
  parameter int               NREGS     = 8,
  parameter int               ZERO_REG  = 0,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int NPORTS = 2;

  logic [NREGS-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic [NREGS-1:0]             pend_q, pend_d;
  logic                         wr_ok, iss_ok;
  logic [NPORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORTS-1:0][WIDTH-1:0]  rd_data;
  logic [NPORTS-1:0]             rd_pend;

  // A strobe only takes effect on an existing, writable entry.
  assign wr_ok  = bus.wr_en && (32'(bus.wr_addr) < NREGS) &&
                  !(ZERO_REG != 0 && bus.wr_addr == '0);
  assign iss_ok = bus.iss_en && (32'(bus.iss_addr) < NREGS) &&
                  !(ZERO_REG != 0 && bus.iss_addr == '0);

  // Next-state: write data per entry; writeback clears pend, issue sets it,
  // and issue wins when both target the same entry (new producer in flight).
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_ok && bus.wr_addr == ADDR_W'(i)) begin
        mem_d[i]  = bus.wr_data;
        pend_d[i] = 1'b0;
      end
      if (iss_ok && bus.iss_addr == ADDR_W'(i))
        pend_d[i] = 1'b1;
    end
  end

  // State update; reset dominates any same-cycle strobes. The hard-zero
  // entry resets to 0 and is never written afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        mem_q[i] <= (ZERO_REG != 0 && i == 0) ? '0 : RESET_VAL;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  assign rd_addr[0]   = bus.rd_addr0;
  assign rd_addr[1]   = bus.rd_addr1;
  assign bus.rd_data0 = rd_data[0];
  assign bus.pend0    = rd_pend[0];
  assign bus.rd_data1 = rd_data[1];
  assign bus.pend1    = rd_pend[1];

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    reg_file_sb_rdport #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .ADDR_W(ADDR_W),
      .BYPASS(BYPASS)
    ) u_rd (
      .mem_i    (mem_q),
      .pend_i   (pend_q),
      .rd_addr_i(rd_addr[p]),
      .wr_ok_i  (wr_ok),
      .wr_addr_i(bus.wr_addr),
      .wr_data_i(bus.wr_data),
      .rd_data_o(rd_data[p]),
      .pend_o   (rd_pend[p])
    );
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two configurations side by side.
//   A: 8 entries, forwarding, RESET_VAL A5A5 (table-driven)
//   B: 6 entries, hard-zero r0, no forwarding (hand-written sequences)
module tb_reg_file_sb;
  logic gclk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 gclk = ~gclk;

  reg_file_sb_if #(.WIDTH(16), .NREGS(8)) ifa ();
  reg_file_sb_if #(.WIDTH(16), .NREGS(6)) ifb ();

  reg_file_sb #(.WIDTH(16), .NREGS(8), .ZERO_REG(0), .BYPASS(1),
                .RESET_VAL(16'hA5A5)) dut_a (.clk(gclk), .rst(rst_a), .bus(ifa));
  reg_file_sb #(.WIDTH(16), .NREGS(6), .ZERO_REG(1), .BYPASS(0),
                .RESET_VAL(16'h0000)) dut_b (.clk(gclk), .rst(rst_b), .bus(ifb));

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        iss_en;
    logic [2:0]  iss_addr;
    logic [2:0]  ra0, ra1;
    logic        chk;
    logic [15:0] d0;
    logic        p0;
    logic [15:0] d1;
    logic        p1;
  } vec_t;

  typedef struct {
    logic        chk;
    int          which;
    int          idx;
    logic [15:0] d0;
    logic        p0;
    logic [15:0] d1;
    logic        p1;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[22];
  int   vnum = 0;

  function automatic vec_t mk(logic r, logic we, logic [2:0] wa, logic [15:0] wd,
                              logic ie, logic [2:0] ia, logic [2:0] a0, logic [2:0] a1,
                              logic c, logic [15:0] e0, logic ep0, logic [15:0] e1,
                              logic ep1);
    vec_t v;
    v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.iss_en = ie; v.iss_addr = ia; v.ra0 = a0; v.ra1 = a1;
    v.chk = c; v.d0 = e0; v.p0 = ep0; v.d1 = e1; v.p1 = ep1;
    return v;
  endfunction

  task automatic cmp(input string name, input int which, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%s step=%0d got=%h expected=%h", name,
               (which == 0) ? "A" : "B", idx, act, exp);
    end
  endtask

  task automatic idle_all();
    rst_a = 1'b0; ifa.wr_en = 1'b0; ifa.iss_en = 1'b0;
    ifa.wr_addr = '0; ifa.wr_data = '0; ifa.iss_addr = '0;
    ifa.rd_addr0 = '0; ifa.rd_addr1 = '0;
    rst_b = 1'b0; ifb.wr_en = 1'b0; ifb.iss_en = 1'b0;
    ifb.wr_addr = '0; ifb.wr_data = '0; ifb.iss_addr = '0;
    ifb.rd_addr0 = '0; ifb.rd_addr1 = '0;
  endtask

  // One cycle: drive on the falling edge, push the expectation, sample the
  // combinational outputs before the rising edge commits the cycle.
  task automatic apply(input vec_t v, input int which);
    exp_t e, got;
    logic [15:0] ad0, ad1;
    logic        ap0, ap1;
    @(negedge gclk);
    idle_all();
    if (which == 0) begin
      rst_a = v.rst; ifa.wr_en = v.wr_en; ifa.wr_addr = v.wr_addr;
      ifa.wr_data = v.wr_data; ifa.iss_en = v.iss_en; ifa.iss_addr = v.iss_addr;
      ifa.rd_addr0 = v.ra0; ifa.rd_addr1 = v.ra1;
    end else begin
      rst_b = v.rst; ifb.wr_en = v.wr_en; ifb.wr_addr = v.wr_addr;
      ifb.wr_data = v.wr_data; ifb.iss_en = v.iss_en; ifb.iss_addr = v.iss_addr;
      ifb.rd_addr0 = v.ra0; ifb.rd_addr1 = v.ra1;
    end
    e.chk = v.chk; e.which = which; e.idx = vnum;
    e.d0 = v.d0; e.p0 = v.p0; e.d1 = v.d1; e.p1 = v.p1;
    sbq.push_back(e);
    vnum++;
    #1;
    if (which == 0) begin
      ad0 = ifa.rd_data0; ap0 = ifa.pend0; ad1 = ifa.rd_data1; ap1 = ifa.pend1;
    end else begin
      ad0 = ifb.rd_data0; ap0 = ifb.pend0; ad1 = ifb.rd_data1; ap1 = ifb.pend1;
    end
    got = sbq.pop_front();
    if (got.chk) begin
      cmp("rd_data0", got.which, got.idx, ad0, got.d0);
      cmp("pend0",    got.which, got.idx, {15'd0, ap0}, {15'd0, got.p0});
      cmp("rd_data1", got.which, got.idx, ad1, got.d1);
      cmp("pend1",    got.which, got.idx, {15'd0, ap1}, {15'd0, got.p1});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    // Config A: {rst, wr_en, wr_addr, wr_data, iss_en, iss_addr, ra0, ra1,
    //            chk, d0, p0, d1, p1}
    tbl[0]  = mk(1, 1, 3, 16'h1111, 1, 3, 3, 0, 0, 16'h0,    0, 16'h0,    0);
    tbl[1]  = mk(0, 0, 0, 16'h0,    0, 0, 3, 0, 1, 16'hA5A5, 0, 16'hA5A5, 0);
    tbl[2]  = mk(0, 0, 0, 16'h0,    0, 0, 7, 7, 1, 16'hA5A5, 0, 16'hA5A5, 0);
    tbl[3]  = mk(0, 1, 3, 16'h1234, 0, 0, 3, 2, 1, 16'h1234, 0, 16'hA5A5, 0);
    tbl[4]  = mk(0, 0, 0, 16'h0,    0, 0, 3, 3, 1, 16'h1234, 0, 16'h1234, 0);
    tbl[5]  = mk(0, 0, 0, 16'h0,    1, 5, 3, 5, 1, 16'h1234, 0, 16'hA5A5, 0);
    tbl[6]  = mk(0, 0, 0, 16'h0,    0, 0, 5, 5, 1, 16'hA5A5, 1, 16'hA5A5, 1);
    tbl[7]  = mk(0, 0, 0, 16'h0,    0, 0, 5, 5, 1, 16'hA5A5, 1, 16'hA5A5, 1);
    tbl[8]  = mk(0, 1, 5, 16'hBEEF, 0, 0, 5, 5, 1, 16'hBEEF, 0, 16'hBEEF, 0);
    tbl[9]  = mk(0, 0, 0, 16'h0,    0, 0, 5, 5, 1, 16'hBEEF, 0, 16'hBEEF, 0);
    tbl[10] = mk(0, 1, 2, 16'h00FF, 1, 2, 2, 4, 1, 16'h00FF, 0, 16'hA5A5, 0);
    tbl[11] = mk(0, 0, 0, 16'h0,    0, 0, 2, 4, 1, 16'h00FF, 1, 16'hA5A5, 0);
    tbl[12] = mk(0, 0, 0, 16'h0,    1, 4, 4, 2, 1, 16'hA5A5, 0, 16'h00FF, 1);
    tbl[13] = mk(0, 1, 4, 16'h1357, 1, 2, 2, 4, 1, 16'h00FF, 1, 16'h1357, 0);
    tbl[14] = mk(0, 0, 0, 16'h0,    0, 0, 2, 4, 1, 16'h00FF, 1, 16'h1357, 0);
    tbl[15] = mk(0, 0, 0, 16'h0,    1, 2, 2, 0, 1, 16'h00FF, 1, 16'hA5A5, 0);
    tbl[16] = mk(0, 1, 2, 16'hAAAA, 0, 0, 2, 2, 1, 16'hAAAA, 0, 16'hAAAA, 0);
    tbl[17] = mk(0, 0, 0, 16'h0,    0, 0, 2, 3, 1, 16'hAAAA, 0, 16'h1234, 0);
    tbl[18] = mk(0, 0, 0, 16'h0,    1, 6, 6, 3, 1, 16'hA5A5, 0, 16'h1234, 0);
    tbl[19] = mk(1, 0, 0, 16'h0,    0, 0, 6, 3, 1, 16'hA5A5, 1, 16'h1234, 0);
    tbl[20] = mk(0, 0, 0, 16'h0,    0, 0, 6, 3, 1, 16'hA5A5, 0, 16'hA5A5, 0);
    tbl[21] = mk(0, 0, 0, 16'h0,    0, 0, 5, 2, 1, 16'hA5A5, 0, 16'hA5A5, 0);
    for (int i = 0; i < 22; i++) apply(tbl[i], 0);

    // Config B: reset, hard-zero entry 0, no forwarding.
    apply(mk(1, 1, 3, 16'hFFFF, 1, 3, 0, 0, 0, 16'h0, 0, 16'h0, 0), 1);
    apply(mk(0, 0, 0, 16'h0,    0, 0, 0, 7, 1, 16'h0, 0, 16'h0, 0), 1);
    apply(mk(0, 1, 0, 16'hFFFF, 1, 0, 0, 3, 1, 16'h0, 0, 16'h0, 0), 1);
    apply(mk(0, 0, 0, 16'h0,    0, 0, 0, 3, 1, 16'h0, 0, 16'h0, 0), 1);
    // Write without forwarding: old value until the edge.
    apply(mk(0, 1, 3, 16'h1234, 0, 0, 3, 3, 1, 16'h0,    0, 16'h0,    0), 1);
    apply(mk(0, 0, 0, 16'h0,    0, 0, 3, 3, 1, 16'h1234, 0, 16'h1234, 0), 1);
    // Out-of-range index 7: ignored on write/issue, reads give 0.
    apply(mk(0, 1, 7, 16'hFFFF, 1, 7, 7, 5, 1, 16'h0, 0, 16'h0, 0), 1);
    apply(mk(0, 0, 0, 16'h0,    0, 0, 7, 5, 1, 16'h0, 0, 16'h0, 0), 1);
    apply(mk(0, 0, 0, 16'h0,    0, 0, 1, 2, 1, 16'h0, 0, 16'h0, 0), 1);
    apply(mk(0, 0, 0, 16'h0,    0, 0, 3, 4, 1, 16'h1234, 0, 16'h0, 0), 1);
    // Issue r5, hold pending 8 cycles, then writeback (no forwarding).
    apply(mk(0, 0, 0, 16'h0,    1, 5, 0, 5, 1, 16'h0, 0, 16'h0, 0), 1);
    for (int k = 0; k < 8; k++)
      apply(mk(0, 0, 0, 16'h0, 0, 0, 0, 5, 1, 16'h0, 0, 16'h0, 1), 1);
    apply(mk(0, 1, 5, 16'hABCD, 0, 0, 5, 5, 1, 16'h0,    1, 16'h0,    1), 1);
    apply(mk(0, 0, 0, 16'h0,    0, 0, 5, 5, 1, 16'hABCD, 0, 16'hABCD, 0), 1);
    // Mid-run reset with pending entries.
    apply(mk(0, 0, 0, 16'h0,    1, 1, 1, 5, 1, 16'h0, 0, 16'hABCD, 0), 1);
    apply(mk(0, 0, 0, 16'h0,    1, 4, 1, 5, 1, 16'h0, 1, 16'hABCD, 0), 1);
    apply(mk(1, 0, 0, 16'h0,    1, 2, 1, 4, 1, 16'h0, 1, 16'h0,    1), 1);
    apply(mk(0, 0, 0, 16'h0,    0, 0, 1, 4, 1, 16'h0, 0, 16'h0,    0), 1);
    apply(mk(0, 0, 0, 16'h0,    0, 0, 2, 5, 1, 16'h0, 0, 16'h0,    0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
